// File: rtl/pipe_pkg.sv
// Shared types for the generic inter-stage pipeline register and the
// per-boundary payloads it carries.
package pipe_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef logic [1:0] occ_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] st_data;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        wb_en;
  } mem_wb_t;

  function automatic occ_t occ_count(input logic a, input logic b);
    return occ_t'({1'b0, a}) + occ_t'({1'b0, b});
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+halt+payload register. Priority: rst > set_bubble > load > clr.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter bit               BUBBLE_VALID = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = WIDTH'(NOP_WORD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_bubble,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_halt,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             halt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      halt  <= 1'b0;
    end else if (set_bubble) begin
      // A slot built without a valid bubble simply empties on squash.
      valid <= BUBBLE_VALID;
      data  <= BUBBLE_VALID ? BUBBLE_VALUE : '0;
      halt  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      halt  <= d_halt;
    end else if (clr) begin
      valid <= 1'b0;
      data  <= '0;
      halt  <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with optional skid entry, squash
// (bubble or kill) and a sticky halt that stops intake until reset.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter bit               SKID         = 1'b1,
  parameter bit               BUBBLE_VALID = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = WIDTH'(NOP_WORD)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_halt,
  input  logic             out_ready,
  input  logic             squash,
  output logic             halted,
  output occ_t             occupancy
);

  logic             accept, emit;
  logic             main_v, main_h, skid_v;
  logic [WIDTH-1:0] main_d;
  logic             main_load, main_clr, main_ld_h;
  logic [WIDTH-1:0] main_ld_d;

  assign accept = in_valid && in_ready;
  assign emit   = main_v && out_ready;

  generate
    if (SKID) begin : g_skid
      logic             main_free, skid_load, skid_h;
      logic [WIDTH-1:0] skid_d;

      assign main_free = !main_v || emit;
      // Registered ready: only the skid state gates intake, never out_ready.
      assign in_ready  = !skid_v && !halted && !squash && !RST;
      assign main_load = main_free && (skid_v || accept);
      assign main_clr  = main_free;
      assign main_ld_d = skid_v ? skid_d : in_data;
      assign main_ld_h = skid_v ? skid_h : in_halt;
      assign skid_load = accept && !main_free;

      pipe_slot #(
        .WIDTH        (WIDTH),
        .BUBBLE_VALID (1'b0),
        .BUBBLE_VALUE ('0)
      ) u_skid (
        .clk        (CLK),
        .rst        (RST),
        .set_bubble (squash),
        .load       (skid_load),
        .clr        (main_free),
        .d_data     (in_data),
        .d_halt     (in_halt),
        .valid      (skid_v),
        .data       (skid_d),
        .halt       (skid_h)
      );
    end else begin : g_noskid
      assign in_ready  = (!main_v || out_ready) && !halted && !squash && !RST;
      assign main_load = accept;
      assign main_clr  = emit;
      assign main_ld_d = in_data;
      assign main_ld_h = in_halt;
      assign skid_v    = 1'b0;
    end
  endgenerate

  pipe_slot #(
    .WIDTH        (WIDTH),
    .BUBBLE_VALID (BUBBLE_VALID),
    .BUBBLE_VALUE (BUBBLE_VALUE)
  ) u_main (
    .clk        (CLK),
    .rst        (RST),
    .set_bubble (squash),
    .load       (main_load),
    .clr        (main_clr),
    .d_data     (main_ld_d),
    .d_halt     (main_ld_h),
    .valid      (main_v),
    .data       (main_d),
    .halt       (main_h)
  );

  // Squash never clears halted: a flushed halt still drains the pipe.
  always_ff @(posedge CLK) begin
    if (RST)                  halted <= 1'b0;
    else if (accept && in_halt) halted <= 1'b1;
  end

  assign out_valid = main_v;
  assign out_data  = main_d;
  assign out_halt  = main_v && main_h;
  assign occupancy = occ_count(main_v, skid_v);

endmodule
